uart_com: RTL and testbench

- 8N1 UART that serves the physical memory controller's serial-port interface.
- Consumes the controller's transmit byte, write strobe and read acknowledge.
- Produces the received byte and the read-ready / write-ready status bits that appear at the COM data and COM status addresses.
- Drives and samples the board RS-232 pins; runs on clk50M.

---
 rtl/uart_com.sv | 188 ++++++++++++++++++
 tb/tb_uart_com.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_com.sv
// 8N1 UART for the memory controller's COM port: independent TX and RX engines,
// a one-byte receive holding register with read-ready / write-ready status.
module uart_com #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       txd,
    input  logic       rxd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          tx_state_reg, tx_state_next;
    logic [CW-1:0]   tx_cnt_reg, tx_cnt_next;
    logic [2:0]      tx_idx_reg, tx_idx_next;
    logic [7:0]      tx_byte_reg, tx_byte_next;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            tx_state_reg <= IDLE;
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_byte_reg  <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_idx_reg   <= tx_idx_next;
            tx_byte_reg  <= tx_byte_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_idx_next   = tx_idx_reg;
        tx_byte_next  = tx_byte_reg;
        case (tx_state_reg)
            IDLE: if (tx_start) begin
                tx_byte_next  = tx_data;
                tx_cnt_next   = '0;
                tx_idx_next   = '0;
                tx_state_next = START;
            end
            START: if (tx_cnt_reg == LAST) begin
                tx_cnt_next   = '0;
                tx_state_next = DATA;
            end else tx_cnt_next = tx_cnt_reg + CW'(1);
            DATA: if (tx_cnt_reg == LAST) begin
                tx_cnt_next = '0;
                if (tx_idx_reg == 3'd7) tx_state_next = STOP;
                else tx_idx_next = tx_idx_reg + 3'd1;
            end else tx_cnt_next = tx_cnt_reg + CW'(1);
            STOP: if (tx_cnt_reg == LAST) begin
                tx_cnt_next   = '0;
                tx_state_next = IDLE;
            end else tx_cnt_next = tx_cnt_reg + CW'(1);
            default: tx_state_next = IDLE;
        endcase
    end

    // txd decodes straight from the state register so reset forces it high at once
    always_comb begin
        txd = 1'b1;
        case (tx_state_reg)
            START:   txd = 1'b0;
            DATA:    txd = tx_byte_reg[tx_idx_reg];
            default: txd = 1'b1;
        endcase
    end

    assign tx_ready = (tx_state_reg == IDLE);

    logic            rx_meta_reg, rxs_reg;
    state_t          rx_state_reg, rx_state_next;
    logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic [2:0]      rx_idx_reg, rx_idx_next;
    logic [7:0]      rx_shift_reg, rx_shift_next;
    logic            rx_brk_reg, rx_brk_next;
    logic [7:0]      rx_data_reg, rx_data_next;
    logic            rx_ready_reg, rx_ready_next;
    logic            frame_err_reg, frame_err_next;
    logic            overrun_reg, overrun_next;
    logic            deliver;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rx_meta_reg   <= 1'b1;
            rxs_reg       <= 1'b1;
            rx_state_reg  <= IDLE;
            rx_cnt_reg    <= '0;
            rx_idx_reg    <= '0;
            rx_shift_reg  <= '0;
            rx_brk_reg    <= 1'b0;
            rx_data_reg   <= '0;
            rx_ready_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            rx_meta_reg   <= rxd;
            rxs_reg       <= rx_meta_reg;
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_idx_reg    <= rx_idx_next;
            rx_shift_reg  <= rx_shift_next;
            rx_brk_reg    <= rx_brk_next;
            rx_data_reg   <= rx_data_next;
            rx_ready_reg  <= rx_ready_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg;
        rx_idx_next    = rx_idx_reg;
        rx_shift_next  = rx_shift_reg;
        rx_brk_next    = rx_brk_reg;
        rx_data_next   = rx_data_reg;
        rx_ready_next  = rx_ready_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        deliver        = 1'b0;
        case (rx_state_reg)
            IDLE: if (!rxs_reg) begin
                rx_cnt_next   = '0;
                rx_state_next = START;
            end
            START: if (rx_cnt_reg == HALF) begin
                rx_cnt_next   = '0;
                rx_idx_next   = '0;
                rx_state_next = rxs_reg ? IDLE : DATA;
            end else rx_cnt_next = rx_cnt_reg + CW'(1);
            DATA: if (rx_cnt_reg == LAST) begin
                rx_cnt_next   = '0;
                rx_shift_next = {rxs_reg, rx_shift_reg[7:1]};
                if (rx_idx_reg == 3'd7) rx_state_next = STOP;
                else rx_idx_next = rx_idx_reg + 3'd1;
            end else rx_cnt_next = rx_cnt_reg + CW'(1);
            STOP: begin
                // After a low stop bit, hold here until the line returns high (break)
                if (rx_brk_reg) begin
                    if (rxs_reg) begin
                        rx_brk_next   = 1'b0;
                        rx_state_next = IDLE;
                    end
                end else if (rx_cnt_reg == LAST) begin
                    rx_cnt_next = '0;
                    if (rxs_reg) begin
                        deliver       = 1'b1;
                        rx_state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        rx_brk_next    = 1'b1;
                    end
                end else rx_cnt_next = rx_cnt_reg + CW'(1);
            end
            default: rx_state_next = IDLE;
        endcase
        // A completing byte takes priority over an acknowledge in the same cycle
        if (deliver) begin
            rx_data_next  = rx_shift_reg;
            rx_ready_next = 1'b1;
            overrun_next  = rx_ready_reg && !rx_ack;
        end else if (rx_ack) begin
            rx_ready_next = 1'b0;
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_ready  = rx_ready_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_com.sv
// Directed bench for uart_com at DIV=16: reset, TX framing, RX, glitch/framing,
// overrun/collision, loopback and mid-frame reset.
module tb_uart_com;
    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       txd;
    logic       rxd;
    logic       rxd_drv = 1'b1;
    logic       loop = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    assign rxd = loop ? txd : rxd_drv;

    uart_com #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk50M(clk50M), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
        .frame_err(frame_err), .overrun(overrun), .txd(txd), .rxd(rxd)
    );

    always #5 clk50M = ~clk50M;

    always @(negedge clk50M) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    // Drives one 8N1 frame on rxd; call right after a negedge.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk50M);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (16) @(negedge clk50M);
        end
        rxd_drv = stop_bit;
        repeat (16) @(negedge clk50M);
        rxd_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk50M);
        n_cmp++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b expected 00", frame_err, overrun); end
        rst = 1'b0;
        $display("reset: txd=%b tx_ready=%b rx_ready=%b rx_data=%h", txd, tx_ready, rx_ready, rx_data);
    endtask

    task automatic test_tx();
        logic [7:0] b;
        logic       exp_txd;
        int         bp;
        int         busy;
        b = 8'hA5;
        busy = 0;
        @(negedge clk50M);
        tx_data = b;
        tx_start = 1'b1;
        for (int e = 0; e < 170; e++) begin
            @(negedge clk50M);
            if (e == 0) tx_start = 1'b0;
            bp = e / 16;
            if (bp == 0) exp_txd = 1'b0;
            else if (bp <= 8) exp_txd = b[bp-1];
            else exp_txd = 1'b1;
            if (!tx_ready) busy++;
            n_cmp++; if (txd !== exp_txd) begin n_err++; $display("FAIL tx_txd cycle %0d: got %b expected %b", e, txd, exp_txd); end
            n_cmp++; if (tx_ready !== (e >= 160)) begin n_err++; $display("FAIL tx_ready cycle %0d: got %b expected %b", e, tx_ready, e >= 160); end
            if (e == 49) begin tx_data = 8'hFF; tx_start = 1'b1; end
            if (e == 50) tx_start = 1'b0;
        end
        n_cmp++; if (busy != 160) begin n_err++; $display("FAIL tx_busy_len: got %0d expected 160", busy); end
        $display("tx: byte=A5 busy_cycles=%0d", busy);
    endtask

    task automatic test_rx();
        int seen;
        seen = 0;
        @(negedge clk50M);
        fork
            rx_frame(8'h3C, 1'b1);
            begin
                for (int i = 1; i <= 200; i++) begin
                    @(negedge clk50M);
                    if (rx_ready && seen == 0) seen = i;
                end
            end
        join
        n_cmp++; if (seen < 148 || seen > 158) begin n_err++; $display("FAIL rx_latency: got %0d expected 148..158", seen); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL rx_data: got %h expected 3c", rx_data); end
        rx_ack = 1'b1;
        @(negedge clk50M);
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_ack_clear: got %b expected 0", rx_ready); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL rx_ack_hold: got %h expected 3c", rx_data); end
        repeat (3) @(negedge clk50M);
        rx_ack = 1'b0;
        @(negedge clk50M);
        n_cmp++; if (rx_ready !== 1'b0 || rx_data !== 8'h3C) begin n_err++; $display("FAIL rx_ack_held: got %b/%h expected 0/3c", rx_ready, rx_data); end
        $display("rx: byte=%h ready_at=%0d", rx_data, seen);
    endtask

    task automatic test_glitch_framing();
        int fe0;
        fe0 = fe_cnt;
        @(negedge clk50M);
        rxd_drv = 1'b0;
        repeat (5) @(negedge clk50M);
        rxd_drv = 1'b1;
        repeat (170) @(negedge clk50M);
        n_cmp++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL glitch_rx_ready: got %b expected 0", rx_ready); end
        n_cmp++; if (fe_cnt != fe0) begin n_err++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
        rx_frame(8'h81, 1'b0);
        repeat (20) @(negedge clk50M);
        n_cmp++; if (fe_cnt != fe0 + 1) begin n_err++; $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - fe0); end
        n_cmp++; if (rx_ready !== 1'b0 || rx_data !== 8'h3C) begin n_err++; $display("FAIL frame_err_hold: got %b/%h expected 0/3c", rx_ready, rx_data); end
        rx_frame(8'h42, 1'b1);
        repeat (4) @(negedge clk50M);
        n_cmp++; if (rx_ready !== 1'b1 || rx_data !== 8'h42) begin n_err++; $display("FAIL after_break_rx: got %b/%h expected 1/42", rx_ready, rx_data); end
        rx_ack = 1'b1;
        @(negedge clk50M);
        rx_ack = 1'b0;
        $display("glitch/framing: frame_errs=%0d last=%h", fe_cnt - fe0, rx_data);
    endtask

    task automatic test_overrun_collision();
        int ov0;
        int ov1;
        ov0 = ov_cnt;
        @(negedge clk50M);
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk50M);
        n_cmp++; if (rx_data !== 8'h22 || rx_ready !== 1'b1) begin n_err++; $display("FAIL overrun_data: got %b/%h expected 1/22", rx_ready, rx_data); end
        n_cmp++; if (ov_cnt != ov0 + 1) begin n_err++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt - ov0); end
        $display("overrun: data=%h pulses=%0d", rx_data, ov_cnt - ov0);
        ov1 = ov_cnt;
        fork
            rx_frame(8'h33, 1'b1);
            begin
                repeat (154) @(negedge clk50M);
                rx_ack = 1'b1;
                @(negedge clk50M);
                rx_ack = 1'b0;
            end
        join
        repeat (4) @(negedge clk50M);
        n_cmp++; if (rx_ready !== 1'b1 || rx_data !== 8'h33) begin n_err++; $display("FAIL collision_data: got %b/%h expected 1/33", rx_ready, rx_data); end
        n_cmp++; if (ov_cnt != ov1) begin n_err++; $display("FAIL collision_overrun: got %0d expected 0", ov_cnt - ov1); end
        rx_ack = 1'b1;
        @(negedge clk50M);
        rx_ack = 1'b0;
        $display("collision: data=%h overruns=%0d", rx_data, ov_cnt - ov1);
    endtask

    task automatic test_loopback();
        logic [7:0] lb [3];
        int fe0;
        int ov0;
        lb = '{8'h00, 8'hFF, 8'h55};
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        loop = 1'b1;
        @(negedge clk50M);
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    for (int c = 0; c < 400 && !tx_ready; c++) @(negedge clk50M);
                    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL loop_tx_wait %0d: got %b expected 1", i, tx_ready); end
                    tx_data = lb[i];
                    tx_start = 1'b1;
                    @(negedge clk50M);
                    tx_start = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    int got;
                    got = 0;
                    for (int c = 0; c < 500; c++) begin
                        @(negedge clk50M);
                        if (rx_ready) begin got = 1; break; end
                    end
                    n_cmp++; if (got != 1 || rx_data !== lb[i]) begin n_err++; $display("FAIL loop_rx %0d: got %0d/%h expected 1/%h", i, got, rx_data, lb[i]); end
                    $display("loopback: byte %0d rx=%h expected %h", i, rx_data, lb[i]);
                    rx_ack = 1'b1;
                    @(negedge clk50M);
                    rx_ack = 1'b0;
                end
            end
        join
        loop = 1'b0;
        n_cmp++; if (fe_cnt != fe0 || ov_cnt != ov0) begin n_err++; $display("FAIL loop_errors: got fe=%0d ov=%0d expected 0/0", fe_cnt - fe0, ov_cnt - ov0); end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        fe0 = fe_cnt;
        @(negedge clk50M);
        tx_data = 8'h0F;
        tx_start = 1'b1;
        rxd_drv = 1'b0;
        @(negedge clk50M);
        tx_start = 1'b0;
        repeat (40) @(negedge clk50M);
        rst = 1'b1;
        rxd_drv = 1'b1;
        @(negedge clk50M);
        rst = 1'b0;
        n_cmp++; if (txd !== 1'b1 || tx_ready !== 1'b1) begin n_err++; $display("FAIL midframe_tx: got %b/%b expected 1/1", txd, tx_ready); end
        repeat (200) @(negedge clk50M);
        n_cmp++; if (rx_ready !== 1'b0 || rx_data !== 8'h00 || fe_cnt != fe0) begin n_err++; $display("FAIL midframe_rx: got %b/%h fe=%0d expected 0/00 fe=0", rx_ready, rx_data, fe_cnt - fe0); end
        $display("midframe reset: txd=%b tx_ready=%b rx_ready=%b", txd, tx_ready, rx_ready);
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_glitch_framing();
        test_overrun_collision();
        test_loopback();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
